// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_serializer block.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } piso_state_t;

  // Largest supported inter-frame gap.
  localparam int unsigned MaxGapCycles = 15;

  // Bit counter is sized for WIDTH+1 frame bits plus headroom, so it never wraps in a frame.
  function automatic int unsigned bit_cnt_width(int unsigned width);
    return $clog2(width + 2);
  endfunction

  function automatic int unsigned gap_cnt_width();
    return $clog2(MaxGapCycles + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter with a terminal-count flag (tc high when the count is zero).
module piso_bit_cnt #(
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] count_q;

  // Load takes priority over decrement; the count holds at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !tc) begin
      count_q <= count_q - CNT_WIDTH'(1);
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word on valid/ready and emits it one bit per
// cycle as ser_out/ser_en, followed by GAP_CYCLES idle cycles.
// Optional macro PISO_SERIALIZER_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             frame_start,
  output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned BitCntW = bit_cnt_width(WIDTH);
  localparam int unsigned GapCntW = gap_cnt_width();

  localparam logic [BitCntW-1:0] BitLoad = BitCntW'(FrameLen - 1);
  localparam logic [GapCntW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapCntW'(GAP_CYCLES - 1) : '0;

  piso_state_t         state_q;
  logic [FrameLen-1:0] shreg_q;
  logic [FrameLen-1:0] frame_word;
  logic                accept;
  logic                last_bit;
  logic                bit_tc;
  logic                gap_tc;

  // Reorder the incoming word so that bit 0 is always the first bit on the wire.
  always_comb begin
    frame_word = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      frame_word[i] = (MSB_FIRST != 0) ? in_data[int'(WIDTH) - 1 - i] : in_data[i];
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    frame_word[FrameLen-1] = ^in_data;
`endif
  end

  // Ready in IDLE, and on the last bit when there is no gap so frames can run back to back.
  always_comb begin
    last_bit = (state_q == SHIFT) && bit_tc;
    in_ready = !rst && ((state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit));
    accept   = in_valid && in_ready;
  end

  piso_bit_cnt #(
    .CNT_WIDTH(BitCntW)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_val(BitLoad),
    .dec     (state_q == SHIFT),
    .tc      (bit_tc)
  );

  piso_bit_cnt #(
    .CNT_WIDTH(GapCntW)
  ) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (last_bit),
    .load_val(GapLoad),
    .dec     (state_q == GAP),
    .tc      (gap_tc)
  );

  // Frame FSM with registered serial outputs; ser_out holds the current bit, shreg_q the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      ser_out     <= 1'b0;
      ser_en      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      state_q     <= SHIFT;
      ser_out     <= frame_word[0];
      shreg_q     <= frame_word >> 1;
      ser_en      <= 1'b1;
      frame_start <= 1'b1;
      busy        <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy <= 1'b0;
        end
        SHIFT: begin
          if (bit_tc) begin
            ser_out <= 1'b0;
            ser_en  <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            ser_out <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        GAP: begin
          if (gap_tc) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ser_out <= 1'b0;
          ser_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (MSB-first gap 1, LSB-first gap 2, MSB-first gap 0)
// driven from per-instance word sources and compared every cycle against a frame-timing model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data     [3];
  logic         in_valid    [3];
  logic         in_ready    [3];
  logic         ser_out     [3];
  logic         ser_en      [3];
  logic         frame_start [3];
  logic         busy        [3];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ser_out(ser_out[0]), .ser_en(ser_en[0]), .frame_start(frame_start[0]), .busy(busy[0])
  );
  piso_serializer #(.WIDTH(W), .GAP_CYCLES(2), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ser_out(ser_out[1]), .ser_en(ser_en[1]), .frame_start(frame_start[1]), .busy(busy[1])
  );
  piso_serializer #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ser_out(ser_out[2]), .ser_en(ser_en[2]), .frame_start(frame_start[2]), .busy(busy[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Word sources: the source presents src_mem[rd] until the model says it was accepted.
  logic [W-1:0] src_mem [3][256];
  int           src_wr  [3];
  int           src_rd  [3];

  // Model: remaining cycles of frame + gap, and the word being sent.
  int           m_left  [3];
  logic [W-1:0] m_word  [3];

  // Observed-stream captures for directed checks.
  logic [63:0]  cap     [3];
  int           fs_cnt  [3];
  int           en_run  [3];
  int           en_max  [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_ready(input int i);
    return !rst && ((m_left[i] == 0) || ((gap_of(i) == 0) && (m_left[i] == 1)));
  endfunction

  // Bit j of a frame: data bits in wire order, then the parity bit if enabled.
  function automatic logic exp_bit(input int i, input logic [W-1:0] w, input int j);
    if (j >= W) return ^w;
    return (i != 1) ? w[W-1-j] : w[j];
  endfunction

  // Frame of an MSB-first instance as it shifts into a capture register.
  function automatic logic [63:0] frame_val(input logic [W-1:0] w);
`ifdef PISO_SERIALIZER_PARITY_EN
    return {55'd0, w, ^w};
`else
    return {56'd0, w};
`endif
  endfunction

  task automatic push(input int i, input logic [W-1:0] w);
    src_mem[i][src_wr[i] % 256] = w;
    src_wr[i]++;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; fs_cnt[i] = 0; en_run[i] = 0; en_max[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      logic acc;
      acc = in_valid[i] && model_ready(i);
      if (rst) begin
        m_left[i] = 0;
      end else if (acc) begin
        m_word[i] = in_data[i];
        m_left[i] = FL + gap_of(i);
        src_rd[i]++;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      int   j;
      logic e_en, e_bit, e_fs, e_busy;
      j      = FL + gap_of(i) - m_left[i];
      e_busy = m_left[i] > 0;
      e_en   = e_busy && (j < FL);
      e_bit  = e_en ? exp_bit(i, m_word[i], j) : 1'b0;
      e_fs   = e_en && (j == 0);
      check($sformatf("ser_en%0d", i), 64'(ser_en[i]), 64'(e_en));
      check($sformatf("ser_out%0d", i), 64'(ser_out[i]), 64'(e_bit));
      check($sformatf("frame_start%0d", i), 64'(frame_start[i]), 64'(e_fs));
      check($sformatf("busy%0d", i), 64'(busy[i]), 64'(e_busy));
      if (ser_en[i] === 1'b1) begin
        cap[i] = (cap[i] << 1) | 64'(ser_out[i]);
        en_run[i]++;
        if (en_run[i] > en_max[i]) en_max[i] = en_run[i];
      end else begin
        en_run[i] = 0;
      end
      if (frame_start[i] === 1'b1) fs_cnt[i]++;
    end
  endtask

  // One clock cycle: drive, check ready, clock the model, check registered outputs.
  task automatic cycle();
    for (int i = 0; i < 3; i++) begin
      if (src_rd[i] != src_wr[i]) begin
        in_valid[i] = 1'b1;
        in_data[i]  = src_mem[i][src_rd[i] % 256];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i]  = W'($urandom);
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("in_ready%0d", i), 64'(in_ready[i]), 64'(model_ready(i)));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0;
      src_wr[i] = 0; src_rd[i] = 0; m_left[i] = 0; m_word[i] = '0;
    end
    clear_caps();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Basic frames: MSB-first A5, LSB-first 01, back-to-back FF/00 with no gap.
    clear_caps();
    push(0, 8'hA5); push(1, 8'h01); push(2, 8'hFF); push(2, 8'h00);
    repeat (30) cycle();
    check("a5_stream", cap[0], frame_val(8'hA5));
`ifdef PISO_SERIALIZER_PARITY_EN
    check("lsb01_stream", cap[1], 64'h101);
`else
    check("lsb01_stream", cap[1], 64'h80);
`endif
    check("b2b_stream", cap[2], (frame_val(8'hFF) << FL) | frame_val(8'h00));
    check("a5_fs_count", 64'(fs_cnt[0]), 64'd1);
    check("b2b_fs_count", 64'(fs_cnt[2]), 64'd2);
    check("b2b_no_bubble", 64'(en_max[2]), 64'(2 * FL));
    check("a5_en_len", 64'(en_max[0]), 64'(FL));

    // Reset during bit 3 of C3 aborts the frame; 3C afterwards is clean.
    clear_caps();
    push(0, 8'hC3);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_en", 64'(ser_en[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    clear_caps();
    push(0, 8'h3C);
    repeat (15) cycle();
    check("after_abort_stream", cap[0], frame_val(8'h3C));
    check("after_abort_fs", 64'(fs_cnt[0]), 64'd1);

    // Backpressure: 55 waits behind 12 while its valid is held high.
    clear_caps();
    push(0, 8'h12); push(0, 8'h55);
    repeat (30) cycle();
    check("bp_stream", cap[0], (frame_val(8'h12) << FL) | frame_val(8'h55));

    // Odd and even parity words.
    clear_caps();
    push(0, 8'h07); push(0, 8'h03);
    repeat (30) cycle();
    check("parity_stream", cap[0], (frame_val(8'h07) << FL) | frame_val(8'h03));

    // Random traffic with occasional resets, every cycle checked against the model.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 3; i++) begin
        if ((src_wr[i] - src_rd[i] < 2) && ($urandom_range(0, 3) == 0)) push(i, W'($urandom));
      end
      cycle();
    end
    rst = 1'b0;
    repeat (40) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle.
- Produces a serial data bit plus an enable strobe. Together they drive the d/en inputs of the downstream single-bit enable flip-flop chain: one bit per enabled clock.
- Sits directly upstream of the flip-flop primitives in the serial datapath.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..64.
- GAP_CYCLES, 1: idle cycles inserted after each frame; legal range 0..15.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial data bit; feeds downstream d.
- ser_en  out  1  ser_out is valid this cycle; feeds downstream en.
- frame_start  out  1  high on the first bit cycle of each frame.
- busy  out  1  high in SHIFT or GAP.

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high.
  - While rst is sampled high: state=IDLE, shift reg=0, bit counter=0, gap counter=0.
  - Outputs during reset: ser_out=0, ser_en=0, frame_start=0, busy=0, in_ready=0.
  - in_ready rises on the first cycle after rst deasserts.
- States (enum in package): IDLE, SHIFT, GAP.
- Accept: a word is accepted on a rising edge where in_valid && in_ready. in_data is captured into the shift register on that edge only; later changes to in_data are ignored.
- Latency: word accepted at edge k → first bit on ser_out with ser_en=1 and frame_start=1 during the cycle after edge k. One bit per cycle follows for FRAME_LEN cycles.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- ser_en, ser_out, frame_start and busy are registered.
  - ser_out=0 whenever ser_en=0.
  - ser_en stays high for exactly FRAME_LEN consecutive cycles per frame.
- IDLE: in_ready=1. On accept → SHIFT.
- SHIFT: the bit counter counts 0..FRAME_LEN-1.
  - Counter width is $clog2(WIDTH+2); no wrap inside a frame.
  - On the last bit cycle, if GAP_CYCLES>0 → GAP; otherwise the next state depends on acceptance.
  - GAP_CYCLES=0: in_ready=1 on the last bit cycle. If a word is accepted there, the next frame starts with no bubble (SHIFT with the counter reset to 0, frame_start=1). If not, → IDLE.
  - in_ready=0 during all other SHIFT cycles.
- GAP: ser_en=0, in_ready=0, busy=1 for exactly GAP_CYCLES cycles, then → IDLE.
- Backpressure: in_valid high while in_ready=0 has no effect. The upstream source must hold the word; nothing is dropped or buffered.
- Reset mid-frame or mid-gap: the frame is aborted.
  - All outputs take reset values on the edge where rst is sampled.
  - No partial resume; the remaining bits are discarded.
- in_valid and rst high on the same edge: reset wins; the word is not accepted.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined: one even-parity bit (XOR of all WIDTH data bits, computed at accept) is appended after the last data bit with ser_en=1. FRAME_LEN=WIDTH+1.
- Undefined: no parity logic; FRAME_LEN=WIDTH.

Decomposition:
- Package piso_pkg:
  - typedef enum logic [1:0] piso_state_t {IDLE, SHIFT, GAP}.
  - Localparam functions for counter widths.
- Sub-module piso_bit_cnt: a loadable down-counter with a terminal-count flag. It is instantiated twice, once for bit count and once for gap count.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=1. Accept 0xA5 at edge 0 → ser_out 1,0,1,0,0,1,0,1 on cycles 1-8 with ser_en=1; frame_start only on cycle 1; cycle 9 in GAP; in_ready=1 on cycle 10.
- MSB_FIRST=0, accept 0x01 → ser_out 1 then seven 0s.
- GAP_CYCLES=0, in_valid held with 0xFF then 0x00 → 16 consecutive ser_en cycles with no bubble; frame_start on cycles 1 and 9.
- Mid-frame: rst high at bit 3 of 0xC3 → ser_en=0, busy=0 next cycle; next accepted word 0x3C is serialized cleanly.
- Backpressure: in_valid=1 with 0x55 while busy, and in_data changed mid-frame → the current frame is unaffected; 0x55 is accepted only once in_ready=1.
- Parity macro defined, accept 0x07 → 9 bits, last bit 1; accept 0x03 → last bit 0.
